// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline stage: default widths, field/ctrl indices, skid state encoding.
package pipe_pkg;

    localparam int PIPE_DATA_W     = 32;
    localparam int PIPE_NUM_FIELDS = 5;
    localparam int PIPE_CTRL_W     = 3;

    localparam int FLD_PC    = 0;
    localparam int FLD_OP1   = 1;
    localparam int FLD_OP2   = 2;
    localparam int FLD_SEXT  = 3;
    localparam int FLD_INSTR = 4;

    localparam int CTRL_REG_WRITE   = 0;
    localparam int CTRL_REG_DST     = 1;
    localparam int CTRL_MEM_REG_DST = 2;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// One storage entry (data + ctrl + valid); clear takes priority over load and only drops the valid bit.
module pipe_skid_buf #(
    parameter int DW     = 160,
    parameter int CTRL_W = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DW-1:0]     in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              valid,
    output logic [DW-1:0]     data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_q, valid_d;
    logic [DW-1:0]     data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            ctrl_d  = in_ctrl;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with valid/ready, flush-to-bubble and a saturating stall counter.
// Define PIPE_SKID_EN to add a second (skid) entry and make in_ready a registered signal.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W      = PIPE_DATA_W,
    parameter int NUM_FIELDS  = PIPE_NUM_FIELDS,
    parameter int CTRL_W      = PIPE_CTRL_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]            out_ctrl,
    input  logic                         stall_clr,
    output logic [STALL_CNT_W-1:0]       stall_count
);

    localparam int DW = NUM_FIELDS * DATA_W;

    logic              in_xfer, out_xfer;
    logic              main_valid, main_load, main_clear;
    logic [DW-1:0]     main_data, main_in_data;
    logic [CTRL_W-1:0] main_ctrl, main_in_ctrl;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_valid & out_ready;

`ifdef PIPE_SKID_EN
    logic              skid_valid, skid_load, skid_clear;
    logic [DW-1:0]     skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    skid_state_e       state;

    // Occupancy is fully described by the two entry valid bits, so the state is decoded rather than stored.
    assign state    = skid_valid ? SKID_FULL : (main_valid ? SKID_ONE : SKID_EMPTY);
    assign in_ready = ~skid_valid;

    always_comb begin
        main_load    = 1'b0;
        main_clear   = 1'b0;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        main_in_data = in_data;
        main_in_ctrl = in_ctrl;
        case (state)
            SKID_EMPTY: main_load = in_xfer;
            SKID_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (in_xfer) begin
                    skid_load = 1'b1;
                end else if (out_xfer) begin
                    main_clear = 1'b1;
                end
            end
            SKID_FULL: begin
                main_in_data = skid_data;
                main_in_ctrl = skid_ctrl;
                if (out_xfer) begin
                    main_load  = 1'b1;
                    skid_clear = 1'b1;
                end
            end
            default: ;
        endcase
        if (flush) begin
            main_load  = 1'b0;
            skid_load  = 1'b0;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end
    end

    pipe_skid_buf #(.DW(DW), .CTRL_W(CTRL_W)) u_skid (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .in_data (in_data),
        .in_ctrl (in_ctrl),
        .valid   (skid_valid),
        .data    (skid_data),
        .ctrl    (skid_ctrl)
    );
`else
    assign in_ready = ~main_valid | out_ready;

    // A word accepted during a flush is dropped even though in_ready was shown.
    always_comb begin
        main_in_data = in_data;
        main_in_ctrl = in_ctrl;
        main_load    = in_xfer & ~flush;
        main_clear   = flush | (out_xfer & ~in_xfer);
    end
`endif

    pipe_skid_buf #(.DW(DW), .CTRL_W(CTRL_W)) u_main (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (main_load),
        .clear   (main_clear),
        .in_data (main_in_data),
        .in_ctrl (main_in_ctrl),
        .valid   (main_valid),
        .data    (main_data),
        .ctrl    (main_ctrl)
    );

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : '0;

    always_comb begin
        stall_d = stall_q;
        if (stall_clr) begin
            stall_d = '0;
        end else if (main_valid && !out_ready && !(&stall_q)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic; a 4-bit-counter instance shares the stimulus for saturation.
module tb_pipe_stage_elastic;

    localparam int DW = 160;

    logic          clock;
    logic          reset_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [2:0]    in_ctrl;
    logic          flush;
    logic          out_ready;
    logic          stall_clr;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    out_ctrl;
    logic [15:0]   stall_count;

    logic          in_ready4, out_valid4;
    logic [DW-1:0] out_data4;
    logic [2:0]    out_ctrl4;
    logic [3:0]    stall_count4;

    int checks = 0;
    int errors = 0;

    pipe_stage_elastic dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_clr(stall_clr), .stall_count(stall_count)
    );

    pipe_stage_elastic #(.STALL_CNT_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .out_ctrl(out_ctrl4),
        .stall_clr(stall_clr), .stall_count(stall_count4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] mkData(input logic [31:0] pc);
        logic [DW-1:0] d;
        d = '0;
        d[0*32 +: 32] = pc;
        d[1*32 +: 32] = pc + 32'd1;
        d[2*32 +: 32] = pc ^ 32'hA5A5_0000;
        d[3*32 +: 32] = pc + 32'h100;
        d[4*32 +: 32] = ~pc;
        return d;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [2:0] ctrl,
                                 input logic ordy, input logic fl, input logic clr);
        in_valid  = v;
        in_data   = mkData(pc);
        in_ctrl   = ctrl;
        out_ready = ordy;
        flush     = fl;
        stall_clr = clr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_ctrl", out_ctrl, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_stall", stall_count, 0);
        reset_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);

        // Stream of eight words at full throughput
        $display("[TB] stream");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 3'b101, 1'b1, 1'b0, 1'b0);
            checkOutput("stream_in_ready", in_ready, 1);
            tick();
            checkOutput("stream_valid", out_valid, 1);
            checkOutput("stream_data", out_data, mkData(32'(i * 4)));
            checkOutput("stream_ctrl", out_ctrl, 3'b101);
        end
        checkOutput("stream_in_ready4", in_ready4, 1);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("stream_drain_valid", out_valid, 0);
        checkOutput("stream_drain_ctrl", out_ctrl, 0);

        // Stall with held word, clear, then saturation on the 4-bit instance
        $display("[TB] stall");
        applyStimulus(1'b1, 32'h40, 3'b011, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("stall_load_valid", out_valid, 1);
        checkOutput("stall_load_data", out_data, mkData(32'h40));
        checkOutput("stall_cnt_start", stall_count, 0);
        applyStimulus(1'b0, 32'h44, 3'b000, 1'b0, 1'b0, 1'b0);
`ifndef PIPE_SKID_EN
        checkOutput("stall_in_ready", in_ready, 0);
`endif
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_data_stable", out_data, mkData(32'h40));
            checkOutput("stall_ctrl_stable", out_ctrl, 3'b011);
        end
        checkOutput("stall_cnt5", stall_count, 5);
        checkOutput("stall_cnt5_w4", stall_count4, 5);
        checkOutput("stall_data4", out_data4, mkData(32'h40));
        checkOutput("stall_ctrl4", out_ctrl4, 3'b011);
        applyStimulus(1'b0, 32'h44, 3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("stall_clr", stall_count, 0);
        checkOutput("stall_clr_w4", stall_count4, 0);
        applyStimulus(1'b0, 32'h44, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        checkOutput("stall_cnt20", stall_count, 20);
        checkOutput("stall_sat_w4", stall_count4, 15);
        checkOutput("stall_valid4", out_valid4, 1);
        applyStimulus(1'b0, 32'h44, 3'b000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("stall_release_valid", out_valid, 0);
        checkOutput("stall_release_cnt", stall_count, 20);
        applyStimulus(1'b0, 32'h44, 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("stall_clr2", stall_count, 0);

        // Flush wins over a simultaneous accepted word
        $display("[TB] flush");
        applyStimulus(1'b1, 32'h7C, 3'b111, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("flush_pre_data", out_data, mkData(32'h7C));
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("flush_pre_cnt", stall_count, 1);
        applyStimulus(1'b1, 32'h80, 3'b111, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_in_ready", in_ready, 1);
        tick();
        checkOutput("flush_valid", out_valid, 0);
        checkOutput("flush_ctrl", out_ctrl, 0);
        checkOutput("flush_keeps_cnt", stall_count, 1);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("flush_no_0x80", out_valid, 0);

        // Control vector on an invalid input never reaches the output
        $display("[TB] bubble");
        applyStimulus(1'b0, 32'h90, 3'b111, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("bubble_ctrl", out_ctrl, 0);
        checkOutput("bubble_valid", out_valid, 0);
        applyStimulus(1'b0, 32'h90, 3'b111, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("bubble_ctrl2", out_ctrl, 0);
        checkOutput("bubble_cnt", stall_count, 1);

        // Asynchronous reset while stalled
        $display("[TB] async reset");
        applyStimulus(1'b1, 32'hA0, 3'b111, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("areset_pre_ctrl", out_ctrl, 3'b111);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("areset_pre_cnt", stall_count, 2);
        reset_n = 1'b0;
        #1;
        checkOutput("areset_valid", out_valid, 0);
        checkOutput("areset_ctrl", out_ctrl, 0);
        checkOutput("areset_cnt", stall_count, 0);
        checkOutput("areset_data", out_data, 0);
        #1;
        reset_n = 1'b1;
        #1;
        checkOutput("areset_in_ready", in_ready, 1);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("areset_after_valid", out_valid, 0);

`ifdef PIPE_SKID_EN
        // Skid entry absorbs a second word under backpressure, order preserved
        $display("[TB] skid");
        applyStimulus(1'b1, 32'h100, 3'b001, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("skid_first", out_data, mkData(32'h100));
        checkOutput("skid_ready1", in_ready, 1);
        applyStimulus(1'b1, 32'h104, 3'b010, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("skid_ready_full", in_ready, 0);
        checkOutput("skid_hold", out_data, mkData(32'h100));
        applyStimulus(1'b1, 32'h108, 3'b100, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("skid_hold2", out_data, mkData(32'h100));
        checkOutput("skid_hold_ctrl", out_ctrl, 3'b001);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("skid_second", out_data, mkData(32'h104));
        checkOutput("skid_second_ctrl", out_ctrl, 3'b010);
        checkOutput("skid_ready_again", in_ready, 1);
        tick();
        checkOutput("skid_empty", out_valid, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
